// File: rtl/char_buffer_arbiter_if.sv
// Host write channel of the character buffer: valid/ready handshake carrying
// one cell code and its (column, row) target.
interface char_buffer_arbiter_if #(
    parameter int unsigned w_char = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [6:0]        wr_col;
    logic [4:0]        wr_row;
    logic [w_char-1:0] wr_char;

    modport master (
        output wr_valid,
        output wr_col,
        output wr_row,
        output wr_char,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_col,
        input  wr_row,
        input  wr_char,
        output wr_ready
    );
endinterface

// File: rtl/char_buffer_arbiter.sv
// Shares one single-port character RAM between the VGA text renderer (always wins),
// a host writer (fills free cycles) and a clear sequencer that fills every cell.
module char_buffer_arbiter #(
    parameter int unsigned screen_width  = 640,
    parameter int unsigned screen_height = 480,
    parameter int unsigned char_w        = 8,
    parameter int unsigned char_h        = 16,
    parameter int unsigned w_char        = 8,
    parameter int unsigned cols          = screen_width / char_w,
    parameter int unsigned rows          = screen_height / char_h,
    parameter int unsigned depth         = cols * rows,
    parameter int unsigned w_x           = $clog2(screen_width),
    parameter int unsigned w_y           = $clog2(screen_height),
    parameter int unsigned w_addr        = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [w_x-1:0]        x,
    input  logic [w_y-1:0]        y,
    input  logic                  display_on,
    char_buffer_arbiter_if.slave  host,
    input  logic                  clear_req,
    input  logic [w_char-1:0]     clear_char,
    output logic                  busy,
    output logic [w_addr-1:0]     ram_addr,
    output logic                  ram_we,
    output logic [w_char-1:0]     ram_wdata,
    input  logic [w_char-1:0]     ram_rdata,
    output logic [w_char-1:0]     disp_char
);
    localparam int unsigned cw_bits = $clog2(char_w);
    localparam int unsigned ch_bits = $clog2(char_h);
    localparam int unsigned w_col   = w_x - cw_bits;
    localparam int unsigned w_row   = w_y - ch_bits;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [w_addr-1:0] clr_cnt_q, clr_cnt_d;
    logic [w_char-1:0] clr_char_q, clr_char_d;
    logic [w_x-1:0]    x_prev_q;
    logic [1:0]        rd_pipe_q;
    logic [w_char-1:0] prefetch_q;
    logic [w_char-1:0] disp_char_q;
    logic [w_addr-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [w_char-1:0] ram_wdata_q, ram_wdata_d;

    logic              x_changed;
    logic              disp_slot;
    logic              load_slot;
    logic              wr_ready;
    logic              wr_fire;
    logic              wr_in_range;
    logic [w_row-1:0]  rd_row;
    logic [w_col-1:0]  rd_col_next;
    logic [w_col-1:0]  rd_col;
    logic [w_addr-1:0] rd_addr;
    logic [w_addr-1:0] wr_addr;
    logic              unused_y_low;

    // row * 80 as two shifts; cols is fixed at 80 for this screen geometry
    function automatic logic [w_addr-1:0] row_base(input logic [w_row-1:0] r);
        return (w_addr'(r) << 6) + (w_addr'(r) << 4);
    endfunction

    assign unused_y_low = ^y[ch_bits-1:0];

    assign x_changed = (x != x_prev_q);
    assign disp_slot = x_changed & display_on &
                       (x[cw_bits-1:0] == cw_bits'(char_w / 2));
    assign load_slot = x_changed & (x[cw_bits-1:0] == '0);

    // Prefetch the cell to the right; the wrap to column 0 is a harmless dummy read.
    assign rd_row      = y[w_y-1:ch_bits];
    assign rd_col_next = x[w_x-1:cw_bits] + w_col'(1);
    assign rd_col      = (rd_col_next == w_col'(cols)) ? '0 : rd_col_next;
    assign rd_addr     = row_base(rd_row) + w_addr'(rd_col);

    assign wr_addr     = row_base(host.wr_row) + w_addr'(host.wr_col);
    assign wr_in_range = (host.wr_col < w_col'(cols)) & (host.wr_row < w_row'(rows));

    assign wr_ready      = ~rst & (state_q == StIdle) & ~disp_slot & ~clear_req;
    assign host.wr_ready = wr_ready;
    assign wr_fire       = host.wr_valid & wr_ready;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        clr_char_d  = clr_char_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (clear_req) begin
                    state_d    = StClear;
                    clr_cnt_d  = '0;
                    clr_char_d = clear_char;
                end
            end
            StClear: begin
                // A display slot steals the port; the clear step simply waits.
                if (!disp_slot) begin
                    ram_addr_d  = clr_cnt_q;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = clr_char_q;
                    clr_cnt_d   = clr_cnt_q + w_addr'(1);
                    if (clr_cnt_q == w_addr'(depth - 1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (disp_slot) begin
            ram_addr_d = rd_addr;
            ram_we_d   = 1'b0;
        end else if (wr_fire && wr_in_range) begin
            ram_addr_d  = wr_addr;
            ram_we_d    = 1'b1;
            ram_wdata_d = host.wr_char;
        end
    end

    always_ff @(posedge clk) begin
        x_prev_q <= x;
        if (rst) begin
            state_q     <= StIdle;
            clr_cnt_q   <= '0;
            clr_char_q  <= '0;
            rd_pipe_q   <= '0;
            prefetch_q  <= '0;
            disp_char_q <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_char_q  <= clr_char_d;
            rd_pipe_q   <= {rd_pipe_q[0], disp_slot};
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            if (rd_pipe_q[1]) begin
                prefetch_q <= ram_rdata;
            end
            if (load_slot) begin
                disp_char_q <= prefetch_q;
            end
        end
    end

    assign busy      = (state_q == StClear);
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign disp_char = disp_char_q;
endmodule

// File: tb/tb_char_buffer_arbiter.sv
// Bench for char_buffer_arbiter: behavioural RAM, write scoreboard fed at stimulus
// time and drained by a monitor, plus per-scenario inline checks.
module tb_char_buffer_arbiter;
    localparam int unsigned Depth = 2400;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        display_on;
    logic        clear_req;
    logic [7:0]  clear_char;
    logic        busy;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  disp_char;

    logic [7:0]  mem [Depth];
    logic        fill_req = 1'b0;
    logic [7:0]  fill_val = 8'h00;
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = '0;
    logic [7:0]  poke_data = 8'h00;

    int unsigned chk_cnt = 0;
    int unsigned pass_cnt = 0;
    int unsigned wr_seen = 0;
    logic [19:0] exp_q [$];

    char_buffer_arbiter_if #(.w_char(8)) host_if ();

    char_buffer_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .display_on (display_on),
        .host       (host_if),
        .clear_req  (clear_req),
        .clear_char (clear_char),
        .busy       (busy),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .disp_char  (disp_char)
    );

    always #5 clk = ~clk;

    // Single-port RAM: registered read, write-first not needed here.
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < Depth; i++) mem[i] <= fill_val;
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end
        if (ram_we && ram_addr < 12'd2400) mem[ram_addr] <= ram_wdata;
        ram_rdata <= (ram_addr < 12'd2400) ? mem[ram_addr] : 8'h00;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic sb_monitor();
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (ram_we) begin
                wr_seen++;
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_write: got addr=%0d data=%h, required no write",
                             ram_addr, ram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({ram_addr, ram_wdata} !== e)
                        $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                                 ram_addr, ram_wdata, e[19:8], e[7:0]);
                    else pass_cnt++;
                end
            end
        end
    endtask

    task automatic do_write(input int col, input int row, input logic [7:0] ch,
                            output bit acc);
        host_if.wr_col   = 7'(col);
        host_if.wr_row   = 5'(row);
        host_if.wr_char  = ch;
        host_if.wr_valid = 1'b1;
        if (col < 80 && row < 30) exp_q.push_back({12'(row * 80 + col), ch});
        acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            #1;
            acc = host_if.wr_ready;
            tick();
        end
        host_if.wr_valid = 1'b0;
        chk_cnt++;
        if (!acc) $display("FAIL wr_accept: col=%0d row=%0d never accepted, required accept",
                           col, row);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; display_on = 1'b0; x = '0; y = '0; clear_req = 1'b0; clear_char = 8'h00;
        host_if.wr_valid = 1'b1; host_if.wr_col = 7'd5; host_if.wr_row = 5'd2;
        host_if.wr_char = 8'h41;
        repeat (3) tick();
        chk_cnt++;
        if (host_if.wr_ready !== 1'b0) $display("FAIL rst_ready: got %b required 0", host_if.wr_ready);
        else pass_cnt++;
        chk_cnt++;
        if (ram_we !== 1'b0) $display("FAIL rst_we: got %b required 0", ram_we); else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else pass_cnt++;
        chk_cnt++;
        if (disp_char !== 8'h00) $display("FAIL rst_disp: got %h required 00", disp_char);
        else pass_cnt++;
        chk_cnt++;
        if (ram_addr !== 12'd0) $display("FAIL rst_addr: got %0d required 0", ram_addr);
        else pass_cnt++;
        host_if.wr_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if (host_if.wr_ready !== 1'b1) $display("FAIL rel_ready: got %b required 1", host_if.wr_ready);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_host_write();
        bit acc;
        do_write(5, 2, 8'h41, acc);
        chk_cnt++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 12'd165, 8'h41})
            $display("FAIL hw_write: got we=%b addr=%0d data=%h required we=1 addr=165 data=41",
                     ram_we, ram_addr, ram_wdata);
        else pass_cnt++;
        do_write(80, 2, 8'h42, acc);
        chk_cnt++;
        if (ram_we !== 1'b0) $display("FAIL hw_col_drop: got we=%b required 0", ram_we);
        else pass_cnt++;
        do_write(3, 30, 8'h43, acc);
        chk_cnt++;
        if (ram_we !== 1'b0) $display("FAIL hw_row_drop: got we=%b required 0", ram_we);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_display_fetch();
        poke_addr = 12'd162; poke_data = 8'h5A; poke_en = 1'b1;
        tick();
        poke_en = 1'b0;
        y = 9'd35; x = 10'd11; display_on = 1'b1;
        tick(); tick();
        x = 10'd12;
        #1;
        chk_cnt++;
        if (host_if.wr_ready !== 1'b0) $display("FAIL df_ready: got %b required 0", host_if.wr_ready);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({ram_addr, ram_we} !== {12'd162, 1'b0})
            $display("FAIL df_read: got addr=%0d we=%b required addr=162 we=0", ram_addr, ram_we);
        else pass_cnt++;
        tick();
        for (int xv = 13; xv <= 15; xv++) begin
            x = 10'(xv);
            tick(); tick();
        end
        chk_cnt++;
        if (disp_char !== 8'h00) $display("FAIL df_hold: got %h required 00", disp_char);
        else pass_cnt++;
        x = 10'd16;
        tick();
        chk_cnt++;
        if (disp_char !== 8'h5A) $display("FAIL df_load: got %h required 5a", disp_char);
        else pass_cnt++;
        tick();
        display_on = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        int reads_ok = 0;
        int bad = 0;
        y = 9'd100;
        display_on = 1'b1;
        fork
            begin
                for (int xv = 0; xv < 640; xv++) begin
                    x = 10'(xv);
                    tick();
                    if (xv % 8 == 4) begin
                        chk_cnt++;
                        if ({ram_addr, ram_we} !== {12'(480 + ((xv / 8 + 1) % 80)), 1'b0})
                            $display("FAIL ct_read: x=%0d got addr=%0d we=%b required addr=%0d we=0",
                                     xv, ram_addr, ram_we, 480 + ((xv / 8 + 1) % 80));
                        else begin
                            pass_cnt++;
                            reads_ok++;
                        end
                    end
                    tick();
                end
            end
            begin
                bit acc;
                for (int i = 0; i < 1000; i++)
                    do_write((1000 + i) % 80, (1000 + i) / 80, 8'(i * 7 + 1), acc);
            end
        join
        display_on = 1'b0;
        tick();
        chk_cnt++;
        if (reads_ok != 80) $display("FAIL ct_reads: got %0d required 80", reads_ok);
        else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL ct_pending: got %0d required 0", exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < 1000; i++) if (mem[1000 + i] !== 8'(i * 7 + 1)) bad++;
        chk_cnt++;
        if (bad != 0) $display("FAIL ct_landed: got %0d bad cells required 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        int n = 0;
        int bad = 0;
        for (int i = 0; i < Depth; i++) exp_q.push_back({12'(i), 8'h20});
        clear_char = 8'h20; clear_req = 1'b1;
        host_if.wr_col = 7'd0; host_if.wr_row = 5'd0; host_if.wr_char = 8'h77;
        host_if.wr_valid = 1'b1;
        #1;
        chk_cnt++;
        if (host_if.wr_ready !== 1'b0) $display("FAIL cl_ready: got %b required 0", host_if.wr_ready);
        else pass_cnt++;
        tick();
        clear_req = 1'b0;
        host_if.wr_valid = 1'b0;
        while (busy && n < 3000) begin
            n++;
            if (n == 100) begin
                clear_req = 1'b1;
                clear_char = 8'h55;
            end else clear_req = 1'b0;
            tick();
        end
        chk_cnt++;
        if (n != 2400) $display("FAIL cl_busy_len: got %0d required 2400", n); else pass_cnt++;
        chk_cnt++;
        if (host_if.wr_ready !== 1'b1) $display("FAIL cl_done_ready: got %b required 1",
                                                host_if.wr_ready);
        else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL cl_pending: got %0d required 0", exp_q.size());
        else pass_cnt++;
        tick();
        for (int i = 0; i < Depth; i++) if (mem[i] !== 8'h20) bad++;
        chk_cnt++;
        if (bad != 0) $display("FAIL cl_cells: got %0d bad cells required 0", bad); else pass_cnt++;
    endtask

    task automatic test_reset_mid_clear();
        int n = 0;
        int bad = 0;
        int unsigned target;
        fill_val = 8'hFF; fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        for (int i = 0; i < Depth; i++) exp_q.push_back({12'(i), 8'h33});
        clear_char = 8'h33; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        target = wr_seen + 1000;
        while (wr_seen < target && n < 3000) begin
            tick();
            n++;
        end
        chk_cnt++;
        if (wr_seen != target) $display("FAIL rm_progress: got %0d required %0d", wr_seen, target);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        chk_cnt++;
        if ({busy, ram_we} !== 2'b00) $display("FAIL rm_abort: got busy=%b we=%b required 0 0",
                                               busy, ram_we);
        else pass_cnt++;
        rst = 1'b0;
        exp_q.delete();
        tick();
        for (int i = 1000; i < Depth; i++) if (mem[i] !== 8'hFF) bad++;
        chk_cnt++;
        if (bad != 0) $display("FAIL rm_kept: got %0d bad cells required 0", bad); else pass_cnt++;
        chk_cnt++;
        if ({mem[0], mem[999]} !== {8'h33, 8'h33})
            $display("FAIL rm_written: got %h %h required 33 33", mem[0], mem[999]);
        else pass_cnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        host_if.wr_valid = 1'b0;
        host_if.wr_col = '0;
        host_if.wr_row = '0;
        host_if.wr_char = '0;
        fork
            sb_monitor();
        join_none
        test_reset();
        test_host_write();
        test_display_fetch();
        test_contention();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/char_buffer_arbiter.md
Name: char_buffer_arbiter

Overview:
Shares one single-port character RAM (80x30 cells, 8-bit codes) between two users: the VGA text renderer, which must read the next cell's code on time, and a host writer (UART command decoder or lab logic). Display reads always win. Host writes use a valid/ready handshake and fill the free cycles. A built-in clear sequencer fills the whole buffer with one code. The block sits between the vga timing generator and the glyph-ROM pixel stage.

Parameters:
screen_width, 640, active pixels per line
screen_height, 480, active lines
char_w, 8, cell width in pixels (power of 2)
char_h, 16, cell height in pixels (power of 2)
cols, screen_width/char_w = 80, cells per row
rows, screen_height/char_h = 30, cell rows
depth, cols*rows = 2400, RAM words
w_x, $clog2(screen_width) = 10, x width
w_y, $clog2(screen_height) = 9, y width
w_addr, $clog2(depth) = 12, RAM address width
w_char, 8, character code width

Ports:
clk  in  1  system clock, 50 MHz; x advances every 2 clk
rst  in  1  synchronous reset, active-high
x  in  w_x  hpos from vga
y  in  w_y  vpos from vga
display_on  in  1  active-area flag from vga
wr_valid  in  1  host write request
wr_ready  out  1  host write accepted this cycle when valid & ready
wr_col  in  7  target column
wr_row  in  5  target row
wr_char  in  w_char  code to write
clear_req  in  1  one-cycle pulse: start clear
clear_char  in  w_char  fill code, sampled with clear_req
busy  out  1  clear in progress
ram_addr  out  w_addr  RAM address, registered
ram_we  out  1  RAM write enable, registered
ram_wdata  out  w_char  RAM write data, registered
ram_rdata  in  w_char  RAM read data, valid 1 clk after read address is presented
disp_char  out  w_char  code of the cell now being drawn

Behaviour:
- Reset values: ram_addr=0, ram_we=0, ram_wdata=0, disp_char=0, busy=0. wr_ready=0 while rst=1. FSM goes to IDLE.
- Display slot (disp_slot): asserted for one clk on the first clk after x changes (compare with a registered x_prev) while display_on=1 and x[log2 char_w-1:0]==char_w/2.
  - Read address = (y/char_h)*cols + (x/char_w + 1).
  - If x/char_w+1 == cols, use column 0 of the same row; that read is unused.
  - cols=80 multiply: (row<<6)+(row<<4).
- Display read pipeline: read issued at cycle T (ram_addr registered at T, ram_we=0). Capture ram_rdata into a prefetch register at T+2. Copy prefetch into disp_char on the clk after x changes with x[log2 char_w-1:0]==0. disp_char holds otherwise.
- Priority per cycle: disp_slot > clear step > host write. Only one RAM access per cycle.
- wr_ready (combinational) = ~rst & state==IDLE & ~disp_slot & ~clear_req.
- Host write handshake: on wr_valid&wr_ready, next cycle ram_we=1, ram_addr=wr_row*cols+wr_col, ram_wdata=wr_char.
  - If wr_col>=cols or wr_row>=rows, the write is accepted but ram_we stays 0 (dropped).
- FSM states:
  - IDLE: clear_req=1 -> CLEAR, clr_cnt=0, latch clear_char, busy=1 next cycle.
  - CLEAR: each cycle without disp_slot, write latched code to clr_cnt and increment. When the write to depth-1 is issued -> IDLE, busy=0 the following cycle.
  - clear_req while in CLEAR is ignored.
- Simultaneous events:
  - clear_req with wr_valid in IDLE: clear wins, the write is not accepted (host retries).
  - disp_slot during CLEAR: the clear step stalls one cycle, clr_cnt holds.
- Blanking (display_on=0): no display slots, so the host or clear gets every cycle. A clear then completes in exactly depth cycles.
- Reset mid-clear: abort immediately, IDLE, cells not yet written keep old contents.
- wr_valid/wr_* must stay stable until accepted; behaviour is undefined otherwise.

Test Plan:
1. Reset: rst=1 for 3 clk with wr_valid=1 -> wr_ready=0, ram_we=0, busy=0, disp_char=0. Release -> wr_ready=1 within 1 clk (display_on=0).
2. Host write in blanking: wr_col=5, wr_row=2, wr_char=8'h41 -> one cycle later ram_we=1, ram_addr=165, ram_wdata=8'h41. wr_col=80 -> accepted, ram_we stays 0.
3. Display fetch: display_on=1, y=35, x goes 11->12 -> next clk ram_addr=2*80+2=162, ram_we=0, wr_ready=0 that cycle. RAM model returns 8'h5A -> disp_char=8'h5A after x reaches 16.
4. Contention: wr_valid held during active line -> every write is deferred past each disp_slot. Over one line there are exactly 80 display reads, none missed, and all host writes land.
5. Clear in blanking: clear_req with clear_char=8'h20 -> busy high for 2400 cycles, addresses 0..2399 written with 8'h20, then busy=0 and wr_ready=1.
6. Reset mid-clear after 1000 writes -> busy=0 next cycle, ram_we=0. Cells 1000..2399 keep their preloaded value 8'hFF.
